// File: rtl/tile_reorder_buffer.sv
// Ping-pong frame buffer: raster-order pixels in, tile-order or raster-order
// pixels out. Each bank holds one full frame; the writer fills one bank while
// the reader drains the other. The output register doubles as the
// synchronous-read register of the bank memories.
module tile_reorder_buffer #(
  parameter int PIX_W  = 8,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 16,
  parameter int TILE_W = 16,
  parameter int TILE_H = 16
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iValid,
  input  logic [PIX_W-1:0]     iData,
  output logic                 oReady,
  input  logic                 iMode,
  output logic                 oValid,
  output logic [PIX_W-1:0]     oData,
  input  logic                 iReady,
  output logic                 oTileDone,
  output logic [$clog2((IMG_W/TILE_W)*(IMG_H/TILE_H)):0] oTileIdx,
  output logic                 oFrameDone
);

  localparam int FR  = IMG_W * IMG_H;
  localparam int AW  = (FR > 1) ? $clog2(FR) : 1;
  localparam int NTX = IMG_W / TILE_W;
  localparam int NTY = IMG_H / TILE_H;
  localparam int IW  = $clog2(NTX * NTY) + 1;

  localparam logic [AW-1:0] A_LAST  = AW'(FR - 1);
  localparam logic [AW-1:0] C_MAX   = AW'(TILE_W - 1);
  localparam logic [AW-1:0] R_MAX   = AW'(TILE_H - 1);
  localparam logic [AW-1:0] TX_MAX  = AW'(NTX - 1);
  localparam logic [AW-1:0] TY_MAX  = AW'(NTY - 1);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_RUN  = 2'd1,
    R_LAST = 2'd2
  } rd_state_t;

  // Storage
  logic [PIX_W-1:0] mem0 [FR];
  logic [PIX_W-1:0] mem1 [FR];

  // Write side
  logic [AW-1:0] wr_addr;
  logic          wr_bank;
  logic [1:0]    full;
  logic          wr_fire;
  logic          wr_last;
  logic [1:0]    full_set;
  logic [1:0]    full_clr;

  // Read side
  rd_state_t     state;
  rd_state_t     state_nxt;
  logic          rd_bank;
  logic          mode_q;
  logic [AW-1:0] c_cnt;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] tx_cnt;
  logic [AW-1:0] ty_cnt;
  logic [AW-1:0] ra_cnt;
  logic [AW-1:0] tile_addr;
  logic [AW-1:0] rd_addr;
  logic          c_end;
  logic          r_end;
  logic          tx_end;
  logic          ty_end;
  logic          ra_end;
  logic          tile_end;
  logic          last_addr;
  logic          ce;
  logic          issue;
  logic          xfer;
  logic          rd_done;
  logic          out_tile_last;
  logic          out_frame_last;

  assign oReady  = !full[wr_bank];
  assign wr_fire = iValid && oReady;
  assign wr_last = wr_fire && (wr_addr == A_LAST);

  // The two banks are never set and cleared in the same cycle for the same
  // bank (a bank being written is not FULL, a bank being read is), so a
  // set mask and a clear mask can be applied together.
  assign full_set = wr_last ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign full_clr = rd_done ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

  // Write pointer, write bank select and per-bank FULL flags
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      wr_addr <= '0;
      wr_bank <= 1'b0;
      full    <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_last) begin
          wr_addr <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_addr <= wr_addr + AW'(1);
        end
      end
      full <= (full | full_set) & ~full_clr;
    end
  end

  // Bank memory write port
  always_ff @(posedge iClk) begin
    if (wr_fire) begin
      if (wr_bank) mem1[wr_addr] <= iData;
      else         mem0[wr_addr] <= iData;
    end
  end

  // Every term below is bounded by FR-1, so AW bits hold all intermediates.
  assign tile_addr = (ty_cnt * AW'(TILE_H) + r_cnt) * AW'(IMG_W)
                   + tx_cnt * AW'(TILE_W) + c_cnt;
  assign rd_addr   = mode_q ? ra_cnt : tile_addr;

  assign c_end     = (c_cnt  == C_MAX);
  assign r_end     = (r_cnt  == R_MAX);
  assign tx_end    = (tx_cnt == TX_MAX);
  assign ty_end    = (ty_cnt == TY_MAX);
  assign ra_end    = (ra_cnt == A_LAST);
  assign tile_end  = c_end && r_end;
  assign last_addr = mode_q ? ra_end : (tile_end && tx_end && ty_end);

  // Output register advances whenever it is empty or being drained.
  assign ce      = !oValid || iReady;
  assign issue   = (state == R_RUN) && ce;
  assign xfer    = oValid && iReady;
  assign rd_done = xfer && out_frame_last;

  assign oTileDone  = xfer && out_tile_last;
  assign oFrameDone = rd_done;

  // Read FSM next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      R_IDLE:  if (full[rd_bank])       state_nxt = R_RUN;
      R_RUN:   if (issue && last_addr)  state_nxt = R_LAST;
      R_LAST:  if (rd_done)             state_nxt = R_IDLE;
      default:                          state_nxt = R_IDLE;
    endcase
  end

  // Read FSM state, frame mode latch and read bank select
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state   <= R_IDLE;
      mode_q  <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == R_IDLE && full[rd_bank]) mode_q <= iMode;
      if (rd_done) rd_bank <= ~rd_bank;
    end
  end

  // Read address counters: raster index, or column/row/tile-x/tile-y nest
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      c_cnt  <= '0;
      r_cnt  <= '0;
      tx_cnt <= '0;
      ty_cnt <= '0;
      ra_cnt <= '0;
    end else if (issue) begin
      if (mode_q) begin
        ra_cnt <= ra_end ? '0 : ra_cnt + AW'(1);
      end else begin
        c_cnt <= c_end ? '0 : c_cnt + AW'(1);
        if (c_end) begin
          r_cnt <= r_end ? '0 : r_cnt + AW'(1);
          if (r_end) begin
            tx_cnt <= tx_end ? '0 : tx_cnt + AW'(1);
            if (tx_end) ty_cnt <= ty_end ? '0 : ty_cnt + AW'(1);
          end
        end
      end
    end
  end

  // Output valid and end-of-tile/frame tags travelling with each pixel
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      oValid         <= 1'b0;
      out_tile_last  <= 1'b0;
      out_frame_last <= 1'b0;
    end else if (ce) begin
      oValid         <= issue;
      out_tile_last  <= issue && !mode_q && tile_end;
      out_frame_last <= issue && last_addr;
    end
  end

  // Synchronous bank read into the output data register
  always_ff @(posedge iClk) begin
    if (issue) oData <= rd_bank ? mem1[rd_addr] : mem0[rd_addr];
  end

  // Tiles completed in the current frame; cleared once the reader is idle
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst)                 oTileIdx <= '0;
    else if (state == R_IDLE)  oTileIdx <= '0;
    else if (oTileDone)        oTileIdx <= oTileIdx + IW'(1);
  end

endmodule
